// File: rtl/l1_dcache_ctrl_pkg.sv
// Shared geometry defaults and controller state encoding for the L1 data cache.
package l1_dcache_ctrl_pkg;

  localparam int unsigned DC_ADDR_W     = 32;
  localparam int unsigned DC_WORD_W     = 32;
  localparam int unsigned DC_LINE_WORDS = 4;
  localparam int unsigned DC_NUM_LINES  = 64;

  typedef enum logic [1:0] {
    DC_IDLE      = 2'd0,
    DC_WRITEBACK = 2'd1,
    DC_REFILL    = 2'd2
  } dc_state_e;

endpackage

// File: rtl/l1_dcache_ctrl_if.sv
// CPU-side and memory-side signal bundle of the L1 data cache controller.
interface l1_dcache_ctrl_if #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned LINE_WORDS = 4
);
  localparam int unsigned LINE_W = WORD_W * LINE_WORDS;
  localparam int unsigned MASK_W = WORD_W / 8;

  // Handshakes: a CPU access is any cycle with cpu_read|cpu_write; it completes at the
  // rising edge ending a cycle where cpu_stall is low, and the CPU must hold its inputs
  // while cpu_stall is high. mem_req is held, with mem_we/mem_addr/mem_wdata stable,
  // until the one-cycle mem_ready pulse that completes the line transfer.
  logic              cpu_read;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_addr;
  logic [WORD_W-1:0] cpu_wdata;
  logic [MASK_W-1:0] cpu_wmask;
  logic [WORD_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata, cpu_wmask,
    output cpu_rdata, cpu_stall,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata, cpu_wmask,
    input  cpu_rdata, cpu_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/l1_dcache_ctrl_store.sv
// Line storage: valid/dirty flops with async reset, plus tag and data arrays
// with a byte-masked word write port and a full-line write port.
module l1_dcache_ctrl_store #(
  parameter int unsigned IDX_W      = 6,
  parameter int unsigned TAG_W      = 22,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [IDX_W-1:0]             rd_idx_i,
  output logic                         rd_valid_o,
  output logic                         rd_dirty_o,
  output logic [TAG_W-1:0]             rd_tag_o,
  output logic [WORD_W*LINE_WORDS-1:0] rd_line_o,
  input  logic                         ww_en_i,
  input  logic [IDX_W-1:0]             ww_idx_i,
  input  logic [$clog2(LINE_WORDS)-1:0] ww_sel_i,
  input  logic [WORD_W-1:0]            ww_data_i,
  input  logic [WORD_W/8-1:0]          ww_mask_i,
  input  logic                         lw_en_i,
  input  logic [IDX_W-1:0]             lw_idx_i,
  input  logic [TAG_W-1:0]             lw_tag_i,
  input  logic [WORD_W*LINE_WORDS-1:0] lw_line_i,
  input  logic                         clr_dirty_i,
  input  logic [IDX_W-1:0]             clr_idx_i
);
  localparam int unsigned NUM_LINES = 1 << IDX_W;
  localparam int unsigned LINE_W    = WORD_W * LINE_WORDS;
  localparam int unsigned MASK_W    = WORD_W / 8;

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [LINE_W-1:0]    data_mem [NUM_LINES];

  // A refill lands clean, so the line write overrides any dirty update to the same index.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (clr_dirty_i) dirty_d[clr_idx_i] = 1'b0;
    if (ww_en_i)     dirty_d[ww_idx_i]  = 1'b1;
    if (lw_en_i) begin
      valid_d[lw_idx_i] = 1'b1;
      dirty_d[lw_idx_i] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (lw_en_i) begin
      tag_mem[lw_idx_i]  <= lw_tag_i;
      data_mem[lw_idx_i] <= lw_line_i;
    end
    if (ww_en_i) begin
      for (int b = 0; b < int'(MASK_W); b++) begin
        if (ww_mask_i[b]) begin
          data_mem[ww_idx_i][int'(ww_sel_i)*int'(WORD_W) + b*8 +: 8] <= ww_data_i[b*8 +: 8];
        end
      end
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_mem[rd_idx_i];
  assign rd_line_o  = data_mem[rd_idx_i];

endmodule

// File: rtl/l1_dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller: zero-latency hits,
// stall-driven writeback/refill on a miss.
module l1_dcache_ctrl
  import l1_dcache_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = DC_ADDR_W,
  parameter int unsigned WORD_W     = DC_WORD_W,
  parameter int unsigned LINE_WORDS = DC_LINE_WORDS,
  parameter int unsigned NUM_LINES  = DC_NUM_LINES
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  l1_dcache_ctrl_if.slave         dc_bus,
  output dc_state_e               state_o
);
  localparam int unsigned WSEL_W = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W  = WSEL_W + 2;
  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned LINE_W = WORD_W * LINE_WORDS;

  dc_state_e         state_q, state_d;
  logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              req;
  logic              hit;
  logic              stall;
  logic [WSEL_W-1:0] addr_wsel;
  logic [IDX_W-1:0]  addr_idx;
  logic [TAG_W-1:0]  addr_tag;
  logic              unused_addr_lsb;

  logic              rd_valid, rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic [IDX_W-1:0]  rd_idx;
  logic              ww_en, lw_en, clr_dirty;

  assign req             = dc_bus.cpu_read | dc_bus.cpu_write;
  assign addr_wsel       = dc_bus.cpu_addr[OFF_W-1:2];
  assign addr_idx        = dc_bus.cpu_addr[OFF_W+IDX_W-1:OFF_W];
  assign addr_tag        = dc_bus.cpu_addr[ADDR_W-1:OFF_W+IDX_W];
  assign unused_addr_lsb = ^dc_bus.cpu_addr[1:0];

  // Outside IDLE the store is looked up with the latched miss index, never the live inputs.
  assign rd_idx = (state_q == DC_IDLE) ? addr_idx : miss_idx_q;
  assign hit    = rd_valid && (rd_tag == addr_tag);

  l1_dcache_ctrl_store #(
    .IDX_W      (IDX_W),
    .TAG_W      (TAG_W),
    .WORD_W     (WORD_W),
    .LINE_WORDS (LINE_WORDS)
  ) u_store (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rd_idx_i    (rd_idx),
    .rd_valid_o  (rd_valid),
    .rd_dirty_o  (rd_dirty),
    .rd_tag_o    (rd_tag),
    .rd_line_o   (rd_line),
    .ww_en_i     (ww_en),
    .ww_idx_i    (addr_idx),
    .ww_sel_i    (addr_wsel),
    .ww_data_i   (dc_bus.cpu_wdata),
    .ww_mask_i   (dc_bus.cpu_wmask),
    .lw_en_i     (lw_en),
    .lw_idx_i    (miss_idx_q),
    .lw_tag_i    (miss_tag_q),
    .lw_line_i   (dc_bus.mem_rdata),
    .clr_dirty_i (clr_dirty),
    .clr_idx_i   (miss_idx_q)
  );

  always_comb begin
    state_d     = state_q;
    miss_tag_d  = miss_tag_q;
    miss_idx_d  = miss_idx_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    stall       = 1'b0;
    ww_en       = 1'b0;
    lw_en       = 1'b0;
    clr_dirty   = 1'b0;
    unique case (state_q)
      DC_IDLE: begin
        if (req && hit) begin
          ww_en = dc_bus.cpu_write;
        end else if (req) begin
          stall      = 1'b1;
          miss_tag_d = addr_tag;
          miss_idx_d = addr_idx;
          mem_req_d  = 1'b1;
          if (rd_valid && rd_dirty) begin
            state_d     = DC_WRITEBACK;
            mem_we_d    = 1'b1;
            mem_addr_d  = {rd_tag, addr_idx, {OFF_W{1'b0}}};
            mem_wdata_d = rd_line;
          end else begin
            state_d    = DC_REFILL;
            mem_we_d   = 1'b0;
            mem_addr_d = {addr_tag, addr_idx, {OFF_W{1'b0}}};
          end
        end
      end
      DC_WRITEBACK: begin
        stall = 1'b1;
        if (dc_bus.mem_ready && mem_req_q) begin
          clr_dirty = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = DC_REFILL;
        end
      end
      DC_REFILL: begin
        stall = 1'b1;
        // After a writeback the request is low for one cycle before the refill is issued.
        if (dc_bus.mem_ready && mem_req_q) begin
          lw_en     = 1'b1;
          mem_req_d = 1'b0;
          state_d   = DC_IDLE;
        end else if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
        end
      end
      default: state_d = DC_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= DC_IDLE;
      miss_tag_q  <= '0;
      miss_idx_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_tag_q  <= miss_tag_d;
      miss_idx_q  <= miss_idx_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign dc_bus.cpu_stall = stall;
  assign dc_bus.cpu_rdata = (state_q == DC_IDLE && req && hit)
                            ? rd_line[int'(addr_wsel)*int'(WORD_W) +: WORD_W] : '0;
  assign dc_bus.mem_req   = mem_req_q;
  assign dc_bus.mem_we    = mem_we_q;
  assign dc_bus.mem_addr  = mem_addr_q;
  assign dc_bus.mem_wdata = mem_wdata_q;
  assign state_o          = state_q;

endmodule
